case_conv_stream: RTL and testbench



---
 rtl/case_conv_pkg.sv | 34 +++
 rtl/case_conv_lane.sv | 31 +++
 rtl/case_conv_stream.sv | 152 +++++++++++++++
 tb/tb_case_conv_stream.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/case_conv_pkg.sv
// case_conv_pkg
// Shared types and constants for the streaming ASCII case converter.
//   mode_e  : packet conversion mode (pass / upper / lower / toggle)
//   state_e : packet-tracking FSM state (IDLE / ACTIVE)
//   letter bounds and the ASCII case bit, plus small letter-class helpers.
package case_conv_pkg;

  typedef enum logic [1:0] {
    MODE_PASS   = 2'd0,
    MODE_UPPER  = 2'd1,
    MODE_LOWER  = 2'd2,
    MODE_TOGGLE = 2'd3
  } mode_e;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_e;

  localparam logic [7:0] UPPER_LO = 8'h41;
  localparam logic [7:0] UPPER_HI = 8'h5A;
  localparam logic [7:0] LOWER_LO = 8'h61;
  localparam logic [7:0] LOWER_HI = 8'h7A;
  localparam int         CASE_BIT = 5;

  function automatic logic is_upper(input logic [7:0] b);
    return (b >= UPPER_LO) && (b <= UPPER_HI);
  endfunction

  function automatic logic is_lower(input logic [7:0] b);
    return (b >= LOWER_LO) && (b <= LOWER_HI);
  endfunction

endpackage

// File: rtl/case_conv_lane.sv
// case_conv_lane
// Combinational single-byte case converter.
// Ports:
//   byte_in  : input byte
//   mode     : conversion mode
//   byte_out : converted byte
//   changed  : high when byte_out differs from byte_in
// Only ASCII letters are touched; everything else (including bytes >= 0x80)
// passes through unchanged.
module case_conv_lane
  import case_conv_pkg::*;
(
  input  logic [7:0] byte_in,
  input  mode_e      mode,
  output logic [7:0] byte_out,
  output logic       changed
);

  always_comb begin
    byte_out = byte_in;
    case (mode)
      MODE_UPPER:  if (is_lower(byte_in)) byte_out[CASE_BIT] = 1'b0;
      MODE_LOWER:  if (is_upper(byte_in)) byte_out[CASE_BIT] = 1'b1;
      MODE_TOGGLE: if (is_upper(byte_in) || is_lower(byte_in))
                     byte_out[CASE_BIT] = ~byte_in[CASE_BIT];
      default:     byte_out = byte_in;
    endcase
    changed = (byte_out != byte_in);
  end

endmodule

// File: rtl/case_conv_stream.sv
// case_conv_stream
// Streaming ASCII case converter, LANES bytes per beat, one registered cycle
// of latency, full throughput, back-pressure absorbed by a one-entry skid.
//
// Optional feature macro: CASE_CONV_STATS_EN (adds conv_count).
//
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   mode_i              : mode for the next packet (sampled on its first beat)
//   in_valid/in_ready   : input handshake; in_data lane 0 in [7:0]; in_last
//   out_valid/out_ready : output handshake; out_data, out_last
//   busy                : packet in progress or any beat held
//   dbg_state           : current packet FSM state
//   conv_count          : saturating count of changed bytes (stats build only)
//
// Handshake: a beat transfers on a rising edge where valid && ready are both
// high. Once valid is raised, data/last are held until that transfer. in_ready
// depends only on the skid register, never combinationally on out_ready.
module case_conv_stream
  import case_conv_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         mode_i,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [8*LANES-1:0] in_data,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [8*LANES-1:0] out_data,
  output logic               out_last,
  output logic               busy,
  output state_e             dbg_state
`ifdef CASE_CONV_STATS_EN
  ,
  output logic [31:0]        conv_count
`endif
);

  localparam int W = 8 * LANES;

  state_e         state_q;
  mode_e          mode_q;
  mode_e          eff_mode;
  logic [W-1:0]   conv_data;
  logic [LANES-1:0] lane_changed;
  logic           accept;

  logic           skid_valid;
  logic [W-1:0]   skid_data;
  logic           skid_last;

  assign in_ready  = ~skid_valid;
  assign accept    = in_valid & in_ready;
  assign busy      = (state_q == ACTIVE) | out_valid | skid_valid;
  assign dbg_state = state_q;

  // The first beat of a packet converts with the live mode; the rest of the
  // packet uses the latched copy so mid-packet mode_i changes are ignored.
  assign eff_mode = (state_q == IDLE) ? mode_e'(mode_i) : mode_q;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    case_conv_lane u_lane (
      .byte_in  (in_data[8*g +: 8]),
      .mode     (eff_mode),
      .byte_out (conv_data[8*g +: 8]),
      .changed  (lane_changed[g])
    );
  end

  // Packet FSM: tracks whether we are inside a multi-beat packet.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mode_q  <= MODE_PASS;
    end else if (accept) begin
      case (state_q)
        IDLE: begin
          mode_q <= mode_e'(mode_i);
          if (!in_last) state_q <= ACTIVE;
        end
        ACTIVE: begin
          if (in_last) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Output register plus skid. When the output register is free (empty or
  // emitting) it takes the skid beat first, else the incoming beat. When the
  // output is stalled, an accepted beat lands in the skid, which then drops
  // in_ready until it drains.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_last   <= 1'b0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      skid_last  <= 1'b0;
    end else if (!out_valid || out_ready) begin
      if (skid_valid) begin
        out_valid  <= 1'b1;
        out_data   <= skid_data;
        out_last   <= skid_last;
        skid_valid <= 1'b0;
      end else if (accept) begin
        out_valid <= 1'b1;
        out_data  <= conv_data;
        out_last  <= in_last;
      end else begin
        out_valid <= 1'b0;
      end
    end else if (accept) begin
      skid_valid <= 1'b1;
      skid_data  <= conv_data;
      skid_last  <= in_last;
    end
  end

`ifdef CASE_CONV_STATS_EN
  logic [31:0] conv_cnt_q;
  logic [31:0] n_changed;
  logic [32:0] cnt_sum;

  always_comb begin
    n_changed = '0;
    for (int i = 0; i < LANES; i++) begin
      n_changed = n_changed + 32'(lane_changed[i]);
    end
    cnt_sum = {1'b0, conv_cnt_q} + {1'b0, n_changed};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conv_cnt_q <= '0;
    end else if (accept) begin
      conv_cnt_q <= cnt_sum[32] ? 32'hFFFF_FFFF : cnt_sum[31:0];
    end
  end

  assign conv_count = conv_cnt_q;
`else
  logic unused_changed;
  assign unused_changed = ^lane_changed;
`endif

endmodule

// File: tb/tb_case_conv_stream.sv
// tb_case_conv_stream
// Directed bench for case_conv_stream (LANES = 4). Stimulus pushes the
// hand-computed expected {last, data} of each accepted beat into exp_q; an
// independent monitor pops and compares on every output transfer.
// Build with CASE_CONV_STATS_EN defined to also exercise conv_count.
module tb_case_conv_stream;
  import case_conv_pkg::*;

  localparam int LANES = 4;
  localparam int W     = 8 * LANES;

  logic         clk;
  logic         rst_n;
  logic [1:0]   mode_i;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         in_last;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         out_last;
  logic         busy;
  state_e       dbg_state;
`ifdef CASE_CONV_STATS_EN
  logic [31:0]  conv_count;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  logic [W:0]   exp_q[$];
  logic [W:0]   exp_beat;
  logic [W-1:0] held_data;
  logic         held_last;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  case_conv_stream #(.LANES(LANES)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode_i    (mode_i),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy),
    .dbg_state (dbg_state)
`ifdef CASE_CONV_STATS_EN
    ,
    .conv_count(conv_count)
`endif
  );

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %0h required %0h", name, act, exp);
  endtask

  // Drive one beat starting at a falling edge; returns just after the
  // rising edge on which it was accepted.
  task automatic send_beat(input logic [W-1:0] data, input logic last,
                           input logic [1:0] mode, input logic [W-1:0] exp_data);
    int   waited = 0;
    logic acc;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = data;
    in_last  = last;
    mode_i   = mode;
    forever begin
      acc = in_ready;
      if (acc) exp_q.push_back({last, exp_data});
      @(posedge clk);
      if (acc) break;
      waited++;
      if (waited > 50) begin
        check("accept_timeout", 64'd0, 64'd1);
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic go_idle();
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      #2;
      if (exp_q.size() == 0) break;
    end
    check(name, 64'(exp_q.size()), 64'd0);
  endtask

  // ---------------- scoreboard monitor ----------------
  always begin
    @(negedge clk);
    #1;
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_beat: actual %0h required none", {out_last, out_data});
      end else begin
        exp_beat = exp_q.pop_front();
        check("out_beat", 64'({out_last, out_data}), 64'(exp_beat));
      end
    end
  end

  // ---------------- directed stimulus ----------------
  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    mode_i    = 2'd0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data",  64'(out_data),  64'd0);
    check("rst_out_last",  64'(out_last),  64'd0);
    check("rst_in_ready",  64'(in_ready),  64'd1);
    check("rst_busy",      64'(busy),      64'd0);
    check("rst_state",     64'(dbg_state), 64'(IDLE));
`ifdef CASE_CONV_STATS_EN
    check("rst_conv_count", 64'(conv_count), 64'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // Mode upper, single beat "abZ!"
    send_beat(32'h215A_6261, 1'b1, 2'd1, 32'h215A_4241);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    #1;
    check("latency_out_valid", 64'(out_valid), 64'd1);
    check("latency_out_last",  64'(out_last),  64'd1);
    check("single_beat_state", 64'(dbg_state), 64'(IDLE));
`ifdef CASE_CONV_STATS_EN
    check("count_upper", 64'(conv_count), 64'd2);
`endif

    // Toggle, letter boundary bytes over two beats
    send_beat(32'h7B60_5B40, 1'b0, 2'd3, 32'h7B60_5B40);
    #1;
    check("toggle_state_active", 64'(dbg_state), 64'(ACTIVE));
    send_beat(32'h20E1_7A41, 1'b1, 2'd3, 32'h20E1_5A61);
    #1;
    check("toggle_state_idle", 64'(dbg_state), 64'(IDLE));

    // 3-beat packet: mode switched mid-packet must be ignored
    send_beat(32'h6463_6261, 1'b0, 2'd1, 32'h4443_4241);
    send_beat(32'h6867_6665, 1'b0, 2'd2, 32'h4847_4645);
    send_beat(32'h6463_4241, 1'b1, 2'd2, 32'h4443_4241);
    // next packet picks up the lower mode
    send_beat(32'h615A_5958, 1'b1, 2'd2, 32'h617A_7978);
    #1;
`ifdef CASE_CONV_STATS_EN
    check("count_after_packets", 64'(conv_count), 64'd17);
`endif
    go_idle();
    drain("drain_packets");

    // 8-beat stream with a 3-cycle output stall
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          send_beat({4{8'(8'h61 + i)}}, (i == 7), 2'd0, {4{8'(8'h61 + i)}});
        end
        go_idle();
      end
      begin
        repeat (3) @(negedge clk);
        out_ready = 1'b0;
        held_data = out_data;
        held_last = out_last;
        #1;
        check("stall_out_valid", 64'(out_valid), 64'd1);
        for (int k = 0; k < 2; k++) begin
          @(negedge clk);
          #1;
          check("stall_in_ready_low", 64'(in_ready), 64'd0);
          check("stall_data_stable",  64'({out_last, out_data}), 64'({held_last, held_data}));
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        check("stall_data_stable_end", 64'({out_last, out_data}), 64'({held_last, held_data}));
        @(negedge clk);
        #1;
        check("stall_in_ready_back", 64'(in_ready), 64'd1);
      end
    join
    drain("drain_stream");

    // Reset during ACTIVE with skid full
    @(negedge clk);
    out_ready = 1'b0;
    send_beat(32'h6463_6261, 1'b0, 2'd1, 32'h4443_4241);
    send_beat(32'h6867_6665, 1'b0, 2'd1, 32'h4847_4645);
    #1;
    check("skid_full_in_ready", 64'(in_ready),  64'd0);
    check("skid_full_busy",     64'(busy),      64'd1);
    check("skid_full_state",    64'(dbg_state), 64'(ACTIVE));
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    rst_n    = 1'b0;
    exp_q.delete();
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_in_ready",  64'(in_ready),  64'd1);
    check("midrst_busy",      64'(busy),      64'd0);
    check("midrst_state",     64'(dbg_state), 64'(IDLE));
`ifdef CASE_CONV_STATS_EN
    check("midrst_count", 64'(conv_count), 64'd0);
`endif
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    send_beat(32'h4443_4241, 1'b1, 2'd2, 32'h6463_6261);
    go_idle();
    drain("drain_after_reset");

`ifdef CASE_CONV_STATS_EN
    // Counter saturation
    @(negedge clk);
    force dut.conv_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.conv_cnt_q;
    send_beat(32'h6463_6261, 1'b1, 2'd1, 32'h4443_4241);
    #1;
    check("count_saturate", 64'(conv_count), 64'hFFFF_FFFF);
    send_beat(32'h2020_2061, 1'b1, 2'd3, 32'h2020_2041);
    #1;
    check("count_hold_sat", 64'(conv_count), 64'hFFFF_FFFF);
    go_idle();
    drain("drain_stats");
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
